// File: rtl/line_writer.sv
// Pen plotter for a 1-bit-per-pixel SRAM frame buffer: draws Bresenham lines
// between successive camera points (PEN_W passes wide) using read-modify-write cycles.
module line_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18,
    parameter int PEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic              erase,
    input  logic [1:0]        pen_mode,
    input  logic [9:0]        cam_x,
    input  logic [9:0]        cam_y,
    input  logic              cam_valid,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read,
    output logic              ram_read,
    output logic              ram_write,
    input  logic              ram_ready,
    output logic              busy,
    output logic              done
);

    localparam int WORDS_PER_ROW = H_RES / DATA_W;
    localparam int TOTAL_WORDS   = H_RES * V_RES / DATA_W;
    localparam int LOG_W         = $clog2(DATA_W);

    typedef enum logic [3:0] {
        S_IDLE, S_ERASE, S_ERASE_WAIT, S_LINE_INIT, S_LINE_STEP,
        S_RD, S_RD_WAIT, S_WR, S_WR_WAIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_address;
    logic [DATA_W-1:0]   r_data_write;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_ram_read;
    logic                r_ram_write;
    logic                r_done;
    logic                r_seen_low;
    logic                r_pen_down;
    logic [9:0]          r_ax, r_ay, r_nx, r_ny, r_cx, r_cy;
    logic [1:0]          r_mode;
    logic [3:0]          r_pass;
    logic signed [12:0]  r_dx, r_dy, r_err;
    logic                r_sx, r_sy;

    logic                w_in_range;
    logic                w_complete;
    logic                w_at_end;
    logic                w_last_pass;
    logic [10:0]         w_px;
    logic                w_px_ok;
    logic [ADDR_W-1:0]   w_pix_addr;
    logic [LOG_W-1:0]    w_bit;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_new_word;
    logic [9:0]          w_adx, w_ady;
    logic signed [13:0]  w_e2, w_dx_ext, w_dy_ext;
    logic                w_step_x, w_step_y;
    logic signed [12:0]  w_err_next;

    assign w_in_range  = ({1'b0, cam_x} < 11'(H_RES)) && ({1'b0, cam_y} < 11'(V_RES));
    // A handshake completes once ram_ready has been seen low and is high again.
    assign w_complete  = ram_ready && r_seen_low;
    assign w_at_end    = (r_cx == r_nx) && (r_cy == r_ny);
    assign w_last_pass = (r_pass == 4'(PEN_W - 1));

    // Pass k shifts the whole line right by k; the stepper itself runs on base coordinates.
    assign w_px       = {1'b0, r_cx} + {7'b0, r_pass};
    assign w_px_ok    = (w_px < 11'(H_RES));
    assign w_pix_addr = ADDR_W'(r_cy) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(w_px >> LOG_W);
    assign w_bit      = w_px[LOG_W-1:0];
    assign w_mask     = DATA_W'(1) << w_bit;

    always_comb begin
        w_new_word = r_rd_data | w_mask;
        case (r_mode)
            2'd1:    w_new_word = r_rd_data & ~w_mask;
            2'd2:    w_new_word = r_rd_data ^ w_mask;
            default: w_new_word = r_rd_data | w_mask;
        endcase
    end

    assign w_adx      = (r_nx >= r_ax) ? (r_nx - r_ax) : (r_ax - r_nx);
    assign w_ady      = (r_ny >= r_ay) ? (r_ny - r_ay) : (r_ay - r_ny);
    assign w_e2       = {r_err, 1'b0};
    assign w_dx_ext   = {r_dx[12], r_dx};
    assign w_dy_ext   = {r_dy[12], r_dy};
    assign w_step_x   = (w_e2 >= w_dy_ext);
    assign w_step_y   = (w_e2 <= w_dx_ext);
    assign w_err_next = r_err + (w_step_x ? r_dy : 13'sd0) + (w_step_y ? r_dx : 13'sd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else if (clk_en) begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (erase)
                        w_state_next = S_ERASE;
                    else if (cam_valid && w_in_range && r_pen_down)
                        w_state_next = S_LINE_INIT;
                end
            end
            S_ERASE:      if (ram_ready) w_state_next = S_ERASE_WAIT;
            S_ERASE_WAIT: begin
                if (w_complete)
                    w_state_next = (r_address == ADDR_W'(TOTAL_WORDS - 1)) ? S_IDLE : S_ERASE;
            end
            S_LINE_INIT:  w_state_next = S_RD;
            S_RD: begin
                if (!w_px_ok)
                    w_state_next = S_LINE_STEP;
                else if (ram_ready)
                    w_state_next = S_RD_WAIT;
            end
            S_RD_WAIT:    if (w_complete) w_state_next = S_WR;
            S_WR:         if (ram_ready) w_state_next = S_WR_WAIT;
            S_WR_WAIT:    if (w_complete) w_state_next = S_LINE_STEP;
            S_LINE_STEP: begin
                if (!w_at_end)
                    w_state_next = S_RD;
                else
                    w_state_next = w_last_pass ? S_IDLE : S_LINE_INIT;
            end
            default:      w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_address    <= '0;
            r_data_write <= '0;
            r_rd_data    <= '0;
            r_ram_read   <= 1'b0;
            r_ram_write  <= 1'b0;
            r_done       <= 1'b0;
            r_seen_low   <= 1'b0;
            r_pen_down   <= 1'b0;
            r_ax         <= '0;
            r_ay         <= '0;
            r_nx         <= '0;
            r_ny         <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_mode       <= '0;
            r_pass       <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_err        <= '0;
            r_sx         <= 1'b0;
            r_sy         <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clk_en) begin
                r_ram_read  <= 1'b0;
                r_ram_write <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (erase) begin
                                r_address  <= '0;
                                r_pen_down <= 1'b0;
                            end else if (cam_valid && w_in_range) begin
                                if (r_pen_down) begin
                                    r_nx   <= cam_x;
                                    r_ny   <= cam_y;
                                    r_mode <= pen_mode;
                                    r_pass <= '0;
                                end else begin
                                    r_ax       <= cam_x;
                                    r_ay       <= cam_y;
                                    r_pen_down <= 1'b1;
                                    r_done     <= 1'b1;
                                end
                            end else begin
                                r_pen_down <= 1'b0;
                            end
                        end
                    end
                    S_ERASE: begin
                        if (ram_ready) begin
                            r_ram_write  <= 1'b1;
                            r_data_write <= '0;
                            r_seen_low   <= 1'b0;
                        end
                    end
                    S_ERASE_WAIT: begin
                        r_seen_low <= r_seen_low | ~ram_ready;
                        if (w_complete) begin
                            if (r_address == ADDR_W'(TOTAL_WORDS - 1))
                                r_done <= 1'b1;
                            else
                                r_address <= r_address + 1'b1;
                        end
                    end
                    S_LINE_INIT: begin
                        r_cx  <= r_ax;
                        r_cy  <= r_ay;
                        r_sx  <= (r_nx < r_ax);
                        r_sy  <= (r_ny < r_ay);
                        r_dx  <= {3'b000, w_adx};
                        r_dy  <= 13'd0 - {3'b000, w_ady};
                        r_err <= {3'b000, w_adx} - {3'b000, w_ady};
                    end
                    S_RD: begin
                        if (w_px_ok && ram_ready) begin
                            r_ram_read <= 1'b1;
                            r_address  <= w_pix_addr;
                            r_seen_low <= 1'b0;
                        end
                    end
                    S_RD_WAIT: begin
                        r_seen_low <= r_seen_low | ~ram_ready;
                        if (w_complete)
                            r_rd_data <= data_read;
                    end
                    S_WR: begin
                        if (ram_ready) begin
                            r_ram_write  <= 1'b1;
                            r_data_write <= w_new_word;
                            r_seen_low   <= 1'b0;
                        end
                    end
                    S_WR_WAIT: begin
                        r_seen_low <= r_seen_low | ~ram_ready;
                    end
                    S_LINE_STEP: begin
                        if (w_at_end) begin
                            if (w_last_pass) begin
                                r_done <= 1'b1;
                                r_ax   <= r_nx;
                                r_ay   <= r_ny;
                            end else begin
                                r_pass <= r_pass + 1'b1;
                            end
                        end else begin
                            if (w_step_x)
                                r_cx <= r_sx ? (r_cx - 10'd1) : (r_cx + 10'd1);
                            if (w_step_y)
                                r_cy <= r_sy ? (r_cy - 10'd1) : (r_cy + 10'd1);
                            r_err <= w_err_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign address    = r_address;
    assign data_write = r_data_write;
    assign ram_read   = r_ram_read;
    assign ram_write  = r_ram_write;
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

endmodule

// File: tb/tb_line_writer.sv
// Random and directed checks of line_writer against a pixel-level frame model
// and a handshaking SRAM model that checks every access as it is issued.
module tb_line_writer;

    localparam int H     = 64;
    localparam int V     = 32;
    localparam int DW    = 16;
    localparam int AW    = 18;
    localparam int PEN   = 2;
    localparam int WPR   = H / DW;
    localparam int TOTAL = H * V / DW;
    localparam int LIMIT = 20000;

    logic          clk;
    logic          reset, clk_en, start, erase, cam_valid;
    logic [1:0]    pen_mode;
    logic [9:0]    cam_x, cam_y;
    logic [AW-1:0] address;
    logic [DW-1:0] data_write, data_read;
    logic          ram_read, ram_write, ram_ready, busy, done;

    line_writer #(.H_RES(H), .V_RES(V), .DATA_W(DW), .ADDR_W(AW), .PEN_W(PEN)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .erase(erase),
        .pen_mode(pen_mode), .cam_x(cam_x), .cam_y(cam_y), .cam_valid(cam_valid),
        .address(address), .data_write(data_write), .data_read(data_read),
        .ram_read(ram_read), .ram_write(ram_write), .ram_ready(ram_ready),
        .busy(busy), .done(done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          wr;
        int          addr;
        logic [15:0] data;
    } acc_t;

    acc_t        exp_q[$];
    logic [15:0] mem[TOTAL];
    logic [15:0] exp_mem[TOTAL];
    int          n_vec = 0, n_err = 0;
    int          done_seen = 0, nacc = 0;
    bit          m_pen = 0;
    int          m_ax = 0, m_ay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // SRAM model: acts once per clk_en edge, holds ram_ready low 1..3 enabled cycles.
    bit          last_en = 0;
    bit          m_busy = 0, m_wr = 0;
    int          m_addr = 0, m_cnt = 0;
    logic [15:0] m_data = 0;

    always @(posedge clk) last_en <= clk_en;

    initial begin
        ram_ready = 1;
        data_read = 0;
    end

    always @(negedge clk) begin
        if (done) done_seen++;
        if (reset) begin
            m_busy    = 0;
            ram_ready = 1;
        end else if (last_en) begin
            if (!m_busy) begin
                if (ram_read || ram_write) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_access: got rd=%0b wr=%0b addr %0d, required none",
                                 ram_read, ram_write, address);
                    end else begin
                        acc_t e;
                        e = exp_q.pop_front();
                        chk("acc_kind", {31'b0, ram_write}, {31'b0, e.wr});
                        chk("acc_addr", 32'(address), e.addr);
                        if (e.wr) chk("acc_data", {16'b0, data_write}, {16'b0, e.data});
                    end
                    if (ram_write && address < AW'(TOTAL)) mem[address] = data_write;
                    m_busy    = 1;
                    m_wr      = ram_write;
                    m_addr    = int'(address);
                    m_data    = data_write;
                    m_cnt     = int'($urandom_range(1, 3));
                    ram_ready = 0;
                    nacc++;
                end
            end else begin
                chk("strobe_drop", {30'b0, ram_read, ram_write}, 0);
                chk("addr_stable", 32'(address), m_addr);
                if (m_wr) chk("data_stable", {16'b0, data_write}, {16'b0, m_data});
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy    = 0;
                    ram_ready = 1;
                    if (!m_wr) data_read = mem[m_addr];
                end
            end
        end
    end

    // Frame model: every pixel of every pass becomes one read then one write.
    task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                              input logic [1:0] m);
        int xs[$], ys[$];
        int dx, dy, sx, sy, err, e2, x, y;
        dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx  = (x0 < x1) ? 1 : -1;
        sy  = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        x   = x0;
        y   = y0;
        for (int i = 0; i < 4096; i++) begin
            xs.push_back(x);
            ys.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
        for (int k = 0; k < PEN; k++) begin
            foreach (xs[i]) begin
                int px, a;
                logic [15:0] msk, nv;
                px = xs[i] + k;
                if (px >= H) continue;
                a   = ys[i] * WPR + px / DW;
                msk = 16'(1) << (px % DW);
                nv  = (m == 2'd1) ? (exp_mem[a] & ~msk) :
                      (m == 2'd2) ? (exp_mem[a] ^ msk) : (exp_mem[a] | msk);
                exp_q.push_back('{0, a, 16'h0});
                exp_q.push_back('{1, a, nv});
                exp_mem[a] = nv;
            end
        end
    endtask

    task automatic model_op(input bit er, input int x, input int y, input bit v,
                            input logic [1:0] m, output int ed);
        ed = -1;
        if (er) begin
            for (int a = 0; a < TOTAL; a++) begin
                exp_q.push_back('{1, a, 16'h0});
                exp_mem[a] = 0;
            end
            m_pen = 0;
            ed    = 1;
        end else if (v && x < H && y < V) begin
            if (m_pen) model_line(m_ax, m_ay, x, y, m);
            m_pen = 1;
            m_ax  = x;
            m_ay  = y;
            ed    = 1;
        end else begin
            m_pen = 0;
        end
    endtask

    task automatic launch(input bit er, input int x, input int y, input bit v, input logic [1:0] m);
        start     = 1;
        erase     = er;
        cam_x     = 10'(x);
        cam_y     = 10'(y);
        cam_valid = v;
        pen_mode  = m;
        clk_en    = 1;
        @(negedge clk);
        start     = 0;
        erase     = 0;
        cam_valid = 0;
    endtask

    task automatic do_op(input bit er, input int x, input int y, input bit v, input logic [1:0] m);
        int ed, d0, cyc;
        model_op(er, x, y, v, m, ed);
        d0 = done_seen;
        launch(er, x, y, v, m);
        cyc = 0;
        // Noise on start/inputs while busy must all be ignored.
        while (busy && cyc < LIMIT) begin
            clk_en    = ($urandom_range(0, 3) != 0);
            start     = 1'($urandom_range(0, 1));
            erase     = 1'($urandom_range(0, 1));
            cam_valid = 1;
            cam_x     = 10'($urandom_range(0, H - 1));
            cam_y     = 10'($urandom_range(0, V - 1));
            pen_mode  = 2'($urandom);
            @(negedge clk);
            cyc++;
        end
        start     = 0;
        erase     = 0;
        cam_valid = 0;
        chk("op_finish_busy", {31'b0, busy}, 0);
        clk_en = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("pending_accesses", exp_q.size(), 0);
        if (ed >= 0) chk("done_count", done_seen - d0, ed);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int a0, d0, orig, nx, ny, r;
        reset = 1; clk_en = 0; start = 0; erase = 0; pen_mode = 0;
        cam_x = 0; cam_y = 0; cam_valid = 0;
        for (int i = 0; i < TOTAL; i++) begin
            mem[i]     = 16'($urandom);
            exp_mem[i] = mem[i];
        end
        repeat (3) @(negedge clk);
        chk("rst_address", 32'(address), 0);
        chk("rst_data_write", {16'b0, data_write}, 0);
        chk("rst_ram_read", {31'b0, ram_read}, 0);
        chk("rst_ram_write", {31'b0, ram_write}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        reset = 0;
        @(negedge clk);

        // Full-frame erase with cam_valid also high: erase must win.
        a0 = nacc;
        do_op(1, 5, 5, 1, 0);
        chk("erase_writes", nacc - a0, TOTAL);
        chk("erase_last_addr", 32'(address), TOTAL - 1);

        // Pen lifted after erase: (0,0) anchors, (3,0) draws two passes.
        a0 = nacc;
        do_op(0, 0, 0, 1, 0);
        chk("anchor_no_access", nacc - a0, 0);
        do_op(0, 3, 0, 1, 0);
        chk("line_accesses", nacc - a0, 16);
        chk("word0_literal", {16'b0, mem[0]}, 32'h001F);
        chk("model_word0_literal", {16'b0, exp_mem[0]}, 32'h001F);

        do_op(0, 0, 0, 0, 0);
        do_op(0, 16, 1, 1, 3);
        do_op(0, 17, 2, 1, 3);
        chk("word5_literal", {16'b0, mem[5]}, 32'h0003);
        chk("word9_literal", {16'b0, mem[9]}, 32'h0006);

        // Toggle a zero-length line twice at (5,5): word 20 returns to its value.
        do_op(0, 0, 0, 0, 0);
        do_op(0, 5, 5, 1, 2);
        orig = int'(mem[20]);
        do_op(0, 5, 5, 1, 2);
        chk("toggle_once", {16'b0, mem[20]}, 32'h0060);
        do_op(0, 5, 5, 1, 2);
        chk("toggle_twice", {16'b0, mem[20]}, orig);

        // Out-of-range point lifts the pen; next point only anchors.
        a0 = nacc;
        do_op(0, 700, 3, 1, 0);
        do_op(0, 10, 3, 1, 0);
        chk("out_of_range_no_access", nacc - a0, 0);

        // Right edge: second pass of x=63 is skipped.
        do_op(0, 0, 0, 0, 0);
        do_op(0, 60, 3, 1, 0);
        do_op(0, 63, 4, 1, 0);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0) begin
                do_op(1, 0, 0, 0, 0);
            end else if (r == 1) begin
                do_op(0, 0, 0, 0, 0);
            end else if (r == 2) begin
                do_op(0, int'($urandom_range(H, 1023)), int'($urandom_range(0, V - 1)), 1, 0);
            end else begin
                nx = m_ax + int'($urandom_range(0, 12)) - 6;
                ny = m_ay + int'($urandom_range(0, 12)) - 6;
                nx = (nx < 0) ? 0 : (nx > H - 1) ? H - 1 : nx;
                ny = (ny < 0) ? 0 : (ny > V - 1) ? V - 1 : ny;
                do_op(0, nx, ny, 1, 2'($urandom));
            end
        end

        // Reset in the middle of a long line, with clk_en low on the reset edge.
        do_op(0, 0, 0, 0, 0);
        do_op(0, 0, 10, 1, 0);
        begin
            int ed;
            model_op(0, 40, 20, 1, 0, ed);
        end
        d0 = done_seen;
        launch(0, 40, 20, 1, 0);
        for (int i = 0; i < 40; i++) begin
            clk_en = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        reset  = 1;
        clk_en = 0;
        @(negedge clk);
        chk("midrst_ram_read", {31'b0, ram_read}, 0);
        chk("midrst_ram_write", {31'b0, ram_write}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_address", 32'(address), 0);
        exp_q.delete();
        for (int i = 0; i < TOTAL; i++) exp_mem[i] = mem[i];
        m_pen = 0;
        m_ax  = 0;
        m_ay  = 0;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 30; i++) begin
            clk_en = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("midrst_no_done", done_seen - d0, 0);
        a0 = nacc;
        do_op(0, 20, 20, 1, 0);
        chk("after_rst_anchor_only", nacc - a0, 0);
        do_op(0, 22, 21, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
